uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//   Parametrised UART transmitter with input FIFO and valid/ready handshake, successor to the fixed 8N1 sender.
//   Configurable data width, parity and stop bits; buffers words so producers (sensor/ASCII formatters) can burst.
//   Sits between data-formatting logic and the board TX pin; frames sent back-to-back with no idle gap.
// PARAMETERS
//   CLK_FREQ   50_000_000  system clock frequency, Hz
//   BAUD       115_200     line rate; BAUD_DIV = CLK_FREQ/BAUD (integer truncation), clocks per bit, must be >= 2
//   DATA_BITS  8           data bits per frame, legal 5..9
//   PARITY     0           0 none, 1 odd, 2 even
//   STOP_BITS  1           1 or 2
//   FIFO_DEPTH 16          input FIFO entries, power of 2, >= 2
// PORTS
//   clk        in   1                      system clock
//   rstn       in   1                      reset, asynchronous, active-low
//   s_data     in   DATA_BITS              word to send
//   s_valid    in   1                      s_data valid
//   s_ready    out  1                      FIFO can accept; = !full
//   tx         out  1                      serial line, idle high
//   busy       out  1                      1 while FSM not IDLE or FIFO non-empty
//   tx_done    out  1                      1-cycle pulse at end of each frame's last stop bit
//   fifo_level out  $clog2(FIFO_DEPTH)+1   words currently buffered (0..FIFO_DEPTH)
// BEHAVIOUR
//   Reset (async, any time incl. mid-frame): tx=1, s_ready=1, busy=0, tx_done=0, fifo_level=0; FIFO flushed, FSM->IDLE.
//   Handshake: word written when s_valid & s_ready at rising edge; s_data ignored otherwise; no overflow possible.
//   FIFO: registered, no bypass; write to empty FIFO visible to FSM on next cycle. Pointers wrap mod FIFO_DEPTH.
//   Simultaneous push and pop: level unchanged; allowed when full only via pop (s_ready already 0, so no push).
//   FSM states: IDLE, START, DATA, PARITY, STOP.
//     IDLE: if FIFO non-empty -> pop head into shift reg, baud cnt=0, tx<=0, go START.
//     START: tx=0 for BAUD_DIV clk; -> DATA, tx<=data[0].
//     DATA: LSB first, each bit BAUD_DIV clk; after bit DATA_BITS-1 -> PARITY (PARITY!=0) else STOP.
//     PARITY: odd tx=~^data, even tx=^data, BAUD_DIV clk; -> STOP.
//     STOP: tx=1 for STOP_BITS*BAUD_DIV clk; at last clock tx_done=1; next: FIFO non-empty -> START (new start bit on next edge), else IDLE.
//   Baud counter width $clog2(BAUD_DIV); counts 0..BAUD_DIV-1, bit boundary at BAUD_DIV-1; cleared in IDLE.
//   Latency: word accepted at edge N -> tx falls at edge N+2. tx changes only at bit boundaries; registered output.
//   Back-to-back: consecutive frames abut; each frame exactly (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*BAUD_DIV clk.
//   Data captured at pop; later s_data changes do not affect frame in flight.
//   busy falls in the cycle after the final tx_done when FIFO empty.
// TESTING (CLK_FREQ=1_000_000, BAUD=100_000 -> BAUD_DIV=10 unless stated)
//   8N1 single word 0xA5 -> tx low at edge N+2; bits 1,0,1,0,0,1,0,1 each 10 clk; stop 10 clk; one tx_done; frame=100 clk.
//   PARITY=1 (odd), 0x03 -> parity bit 1; PARITY=2 (even), 0x03 -> parity bit 0; frame=110 clk.
//   DATA_BITS=7, STOP_BITS=2, 0x41 -> 7 data bits LSB first, tx high 20 clk, frame=100 clk.
//   Burst 20 words with FIFO_DEPTH=16, s_valid held -> s_ready drops when level=16; all 20 sent in order, no gap, 20 tx_done.
//   Reset asserted mid-DATA of 0x55 with 3 queued -> tx=1 immediately, level=0, no further frames after release.
//   Push to empty FIFO while last stop bit of prior frame ends -> next start bit immediately follows, no idle cycle.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with input FIFO and valid/ready handshake.
// Configurable data width, parity and stop bits; frames sent back-to-back.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [DATA_BITS-1:0]          s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic                          tx,
    output logic                          busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CW = $clog2(BAUD_DIV);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);
    localparam logic          PAR_ODD   = (PARITY == 1);
    localparam logic          PAR_EN    = (PARITY != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  avail_q, avail_d;
    logic [DATA_BITS-1:0]  mem_q [FIFO_DEPTH];

    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  load;
    logic                  done;
    logic                  bit_end;
    logic [DATA_BITS-1:0]  head;

    assign full  = (level_q == LVL_FULL);
    assign empty = (level_q == '0);
    assign push  = s_valid && !full;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        avail_d  = !empty;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= s_data;
    end

    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        load    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                // avail_q lags level by a cycle so a fresh word leaves at N+2
                if (avail_q && !empty) load = 1'b1;
            end
            S_START: begin
                if (bit_end) begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (PAR_EN) begin
                            tx_d    = par_q;
                            state_d = S_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = S_STOP;
                        end
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + BW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    bit_d   = '0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        done = 1'b1;
                        if (!empty) begin
                            load = 1'b1;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
        if (load) begin
            shift_d = head;
            par_d   = (^head) ^ PAR_ODD;
            tx_d    = 1'b0;
            cnt_d   = '0;
            bit_d   = '0;
            state_d = S_START;
        end
    end

    assign pop = load;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            avail_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            avail_q  <= avail_d;
        end
    end

    assign tx         = tx_q;
    assign s_ready    = !full;
    assign busy       = (state_q != S_IDLE) || !empty;
    assign tx_done    = done;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 8N1, odd/even parity, 7N2,
// burst through a full FIFO, back-to-back push and mid-frame reset.
module tb_uart_tx_fifo;

    logic       clk;
    logic       rstn;
    logic [8:0] sdata  [4];
    logic       svalid [4];
    logic       sready [4];
    logic       tx     [4];
    logic       busy   [4];
    logic       txd    [4];
    logic [4:0] lvl    [4];

    int n_chk = 0;
    int n_err = 0;

    uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
                   .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_8n1 (
        .clk(clk), .rstn(rstn), .s_data(sdata[0][7:0]), .s_valid(svalid[0]),
        .s_ready(sready[0]), .tx(tx[0]), .busy(busy[0]), .tx_done(txd[0]),
        .fifo_level(lvl[0]));

    uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
                   .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) u_8o1 (
        .clk(clk), .rstn(rstn), .s_data(sdata[1][7:0]), .s_valid(svalid[1]),
        .s_ready(sready[1]), .tx(tx[1]), .busy(busy[1]), .tx_done(txd[1]),
        .fifo_level(lvl[1]));

    uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
                   .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u_8e1 (
        .clk(clk), .rstn(rstn), .s_data(sdata[2][7:0]), .s_valid(svalid[2]),
        .s_ready(sready[2]), .tx(tx[2]), .busy(busy[2]), .tx_done(txd[2]),
        .fifo_level(lvl[2]));

    uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(7),
                   .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16)) u_7n2 (
        .clk(clk), .rstn(rstn), .s_data(sdata[3][6:0]), .s_valid(svalid[3]),
        .s_ready(sready[3]), .tx(tx[3]), .busy(busy[3]), .tx_done(txd[3]),
        .fifo_level(lvl[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns #1 after the accepting edge, with s_data scrambled afterwards.
    task automatic push(input int id, input logic [8:0] d);
        @(negedge clk);
        sdata[id]  = d;
        svalid[id] = 1'b1;
        @(posedge clk);
        #1;
        svalid[id] = 1'b0;
        sdata[id]  = ~d;
    endtask

    // Starts sampling at #1 after the frame's first edge; bit k of frame
    // is the line value during bit period k.
    task automatic frame_check(input int id, input logic [15:0] frame,
                               input int nb, input string tag);
        int len;
        len = nb * 10;
        for (int i = 0; i < len; i++) begin
            chk($sformatf("%s tx@%0d", tag, i), int'(tx[id]), int'(frame[i/10]));
            chk($sformatf("%s done@%0d", tag, i), int'(txd[id]), int'(i == len - 1));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic single(input int id, input logic [8:0] d,
                          input logic [15:0] frame, input int nb,
                          input string tag);
        push(id, d);
        chk({tag, " lvl N"}, int'(lvl[id]), 1);
        chk({tag, " tx N"}, int'(tx[id]), 1);
        chk({tag, " busy N"}, int'(busy[id]), 1);
        @(posedge clk);
        #1;
        chk({tag, " tx N+1"}, int'(tx[id]), 1);
        @(posedge clk);
        #1;
        frame_check(id, frame, nb, tag);
        chk({tag, " idle tx"}, int'(tx[id]), 1);
        chk({tag, " idle busy"}, int'(busy[id]), 0);
        chk({tag, " idle lvl"}, int'(lvl[id]), 0);
    endtask

    logic [7:0] words [20];

    initial begin
        for (int i = 0; i < 4; i++) begin
            sdata[i]  = '0;
            svalid[i] = 1'b0;
        end
        for (int i = 0; i < 20; i++) words[i] = 8'(i * 37 + 3);
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst tx", int'(tx[0]), 1);
        chk("rst s_ready", int'(sready[0]), 1);
        chk("rst busy", int'(busy[0]), 0);
        chk("rst tx_done", int'(txd[0]), 0);
        chk("rst level", int'(lvl[0]), 0);
        chk("rst tx 7n2", int'(tx[3]), 1);
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 0xA5 LSB first: start 0, 1,0,1,0,0,1,0,1, stop 1
        single(0, 9'h0A5, 16'b0000_0011_0100_1010, 10, "8n1 a5");
        // 0x03 has even ones: odd parity bit 1, even parity bit 0
        single(1, 9'h003, 16'b0000_0110_0000_0110, 11, "odd 03");
        single(2, 9'h003, 16'b0000_0100_0000_0110, 11, "even 03");
        // 0x41 in 7 bits: 1,0,0,0,0,0,1 then two stop bits
        single(3, 9'h041, 16'b0000_0111_1000_0010, 10, "7n2 41");

        // Burst of 20 through a 16-deep FIFO with s_valid held.
        fork
            begin
                int idx;
                int saw_full;
                logic rdy;
                idx = 0;
                saw_full = 0;
                for (int cyc = 0; cyc < 3000 && idx < 20; cyc++) begin
                    @(negedge clk);
                    sdata[0]  = {1'b0, words[idx]};
                    svalid[0] = 1'b1;
                    rdy = sready[0];
                    if (!rdy && saw_full == 0) begin
                        saw_full = 1;
                        chk("burst level at full", int'(lvl[0]), 16);
                    end
                    @(posedge clk);
                    if (rdy) idx++;
                end
                @(negedge clk);
                svalid[0] = 1'b0;
                chk("burst words pushed", idx, 20);
                chk("burst s_ready dropped", saw_full, 1);
            end
            begin
                repeat (3) begin
                    @(posedge clk);
                    #1;
                end
                for (int k = 0; k < 20; k++)
                    frame_check(0, {6'b0, 1'b1, words[k], 1'b0}, 10,
                                $sformatf("burst f%0d", k));
            end
        join
        chk("burst end tx", int'(tx[0]), 1);
        chk("burst end busy", int'(busy[0]), 0);
        chk("burst end lvl", int'(lvl[0]), 0);
        repeat (3) @(posedge clk);
        #1;

        // Word pushed at the start of the last stop cycle must abut.
        push(0, 9'h0C3);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        fork
            begin
                frame_check(0, 16'b0000_0011_1000_0110, 10, "abut c3");
                frame_check(0, 16'b0000_0010_0111_1000, 10, "abut 3c");
            end
            begin
                repeat (98) @(posedge clk);
                @(negedge clk);
                sdata[0]  = 9'h03C;
                svalid[0] = 1'b1;
                @(posedge clk);
                #1;
                svalid[0] = 1'b0;
                sdata[0]  = 9'h1FF;
                chk("abut lvl", int'(lvl[0]), 1);
            end
        join
        chk("abut end busy", int'(busy[0]), 0);

        // Reset in the middle of 0x55 with three words still queued.
        push(0, 9'h055);
        push(0, 9'h011);
        push(0, 9'h022);
        push(0, 9'h033);
        repeat (27) @(posedge clk);
        #1;
        chk("pre-rst lvl", int'(lvl[0]), 3);
        chk("pre-rst tx", int'(tx[0]), 0);
        #3;
        rstn = 1'b0;
        #1;
        chk("mid rst tx", int'(tx[0]), 1);
        chk("mid rst lvl", int'(lvl[0]), 0);
        chk("mid rst busy", int'(busy[0]), 0);
        chk("mid rst s_ready", int'(sready[0]), 1);
        chk("mid rst tx_done", int'(txd[0]), 0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        begin
            int lows;
            int dones;
            lows = 0;
            dones = 0;
            for (int i = 0; i < 300; i++) begin
                @(posedge clk);
                #1;
                if (tx[0] !== 1'b1) lows++;
                if (txd[0] !== 1'b0) dones++;
            end
            chk("post-rst tx low cycles", lows, 0);
            chk("post-rst tx_done pulses", dones, 0);
            chk("post-rst lvl", int'(lvl[0]), 0);
            chk("post-rst busy", int'(busy[0]), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
